dxt_div: RTL and testbench
==========================

Name: dxt_div

Overview:
- Streaming adjoint (transposed) horizontal-difference engine for the GAP-TV datapath; it undoes the direction of dx_diff.
- Reads a frame of horizontal gradients d from BRAM, one PORT_SIZE-lane word per cycle. Computes the divergence term Dx^T d and writes it back through a separate BRAM write port.
- Used in the TV denoising step to return from the gradient domain to the image domain.

Parameters:
- PORT_SIZE, 32: 16-bit pixel lanes per BRAM word; lane 0 = bits[15:0] = leftmost pixel.
- COL_WIDTH, 2: words per image row; row length N = PORT_SIZE*COL_WIDTH.
- ROW_NUM, 48: rows per frame.
- ADDR_W, 8: BRAM address width; requires ROW_NUM*COL_WIDTH <= 2^ADDR_W.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  one-cycle pulse; begins a frame pass when idle
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at frame completion
- ren  output  1  BRAM read enable
- raddr  output  ADDR_W  read word address = row*COL_WIDTH + col
- din  input  PORT_SIZE*16  read data, valid one cycle after ren (registered BRAM)
- wen  output  1  BRAM write enable
- waddr  output  ADDR_W  write word address
- dout  output  PORT_SIZE*16  write data

Behaviour:
- Reset: all outputs 0; state IDLE; row/col counters and carry register prev are 0. A reset mid-pass aborts the pass immediately; no further wen pulses occur.
- FSM states and transitions:
  - IDLE: start=1 moves to RUN. start is ignored in all other states.
  - RUN: ren=1 each cycle. Scan order is col 0..COL_WIDTH-1 within a row, then row 0..ROW_NUM-1, so raddr = 0,1,2,...,ROW_NUM*COL_WIDTH-1. After the last address is issued, move to DRAIN.
  - DRAIN: ren=0; wait for the last two pipeline stages to retire, then move to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Pipeline:
  - Stage 1: issue ren/raddr.
  - Stage 2: din arrives.
  - Stage 2 result registers into dout with wen=1 and waddr = the raddr issued two cycles earlier.
  - Read-to-write latency is 2 cycles; throughput is 1 word per cycle, with no bubbles within or between rows.
- Arithmetic (pixel index j = col*PORT_SIZE + lane, 0..N-1):
  - out[0] = 0 - d[0]
  - out[j] = d[j-1] - d[j] for 0 < j < N-1
  - out[N-1] = d[N-2] (d[N-1] is treated as 0, the Neumann boundary)
- Lane carry:
  - For lane 0 of a word with col > 0, d[j-1] comes from prev.
  - prev captures din lane PORT_SIZE-1 at each processed word.
  - prev is forced to 0 for col==0 of every row; no carry crosses a row boundary.
- Width: 16-bit two's-complement subtract, result wraps modulo 2^16 (see optional feature).
- din is sampled only in the stage matching an issued ren; din is ignored otherwise.

Optional Feature:
- Macro DXT_DIV_SAT_EN.
- Defined: each lane subtraction is computed at 17 bits and saturated to [-32768, 32767].
- Undefined: plain 16-bit wrap.
- Latency and throughput are identical in both builds.

Test Plan:
- All-zero frame:
  - start at cycle 0 -> ren high for 96 consecutive cycles, raddr 0..95.
  - wen high for 96 consecutive cycles, 2 cycles after each read, waddr 0..95, dout all 0.
  - done is a single pulse the cycle after the last wen; busy falls with done.
- Constant d=1 for all pixels -> in every row:
  - out[0] = 0xFFFF (-1);
  - out[1..62] = 0;
  - out[63] = 1 (col1 lane31).
- Ramp d[j]=j per row:
  - out[0] = 0; out[j] = -1 for 1 <= j <= 62, including j=32 (col1 lane0, exercises the prev carry); out[63] = 62.
  - Row 1 lane0 = 0, proving prev cleared at row start.
- Overflow case, d[31]=32767 and d[32]=-32768:
  - wrap build: out[32] = 0xFFFF;
  - DXT_DIV_SAT_EN build: out[32] = 0x7FFF.
- Start while busy:
  - second start pulse at cycle 10 -> ignored, exactly 96 writes, one done.
- Reset mid-pass:
  - rst_n=0 for 1 cycle at cycle 40 -> next cycle ren=wen=busy=done=0, raddr=waddr=dout=0.
  - A subsequent start runs a full clean pass from address 0.

Source files
------------

// File: rtl/dxt_div_if.sv
// Bus bundle for dxt_div: frame handshake, BRAM read port and BRAM write port.
interface dxt_div_if #(
   parameter int unsigned PORT_SIZE = 32,
   parameter int unsigned ADDR_W    = 8
);
   localparam int unsigned DW = PORT_SIZE * 16;

   logic              start;
   logic              busy;
   logic              done;
   logic              ren;
   logic [ADDR_W-1:0] raddr;
   logic [DW-1:0]     din;
   logic              wen;
   logic [ADDR_W-1:0] waddr;
   logic [DW-1:0]     dout;

   modport master (
      output start, din,
      input  busy, done, ren, raddr, wen, waddr, dout
   );

   modport slave (
      input  start, din,
      output busy, done, ren, raddr, wen, waddr, dout
   );
endinterface

// File: rtl/dxt_div.sv
// Streaming adjoint horizontal difference (Dx^T d) over a BRAM frame, 1 word/cycle.
// Optional macro DXT_DIV_SAT_EN: saturate each lane difference instead of wrapping.
module dxt_div #(
   parameter int unsigned PORT_SIZE = 32,
   parameter int unsigned COL_WIDTH = 2,
   parameter int unsigned ROW_NUM   = 48,
   parameter int unsigned ADDR_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   dxt_div_if.slave   bus
);

   localparam int unsigned DW   = PORT_SIZE * 16;
   localparam int unsigned CW_W = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;
   localparam int unsigned RW_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e            state_q;
   logic [RW_W-1:0]   row_q;
   logic [CW_W-1:0]   col_q;
   logic              v1_q;
   logic [ADDR_W-1:0] a1_q;
   logic [CW_W-1:0]   c1_q;
   logic [15:0]       prev_q;
   logic              busy_q;
   logic              done_q;
   logic              ren_q;
   logic [ADDR_W-1:0] raddr_q;
   logic              wen_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [DW-1:0]     dout_q;
   logic [DW-1:0]     dout_d;

   logic [15:0]       prev_sel;
   logic [DW+15:0]    dprev_vec;
   logic [15:0]       lhs;
   logic [15:0]       rhs;

   function automatic logic [15:0] sub16(input logic [15:0] a, input logic [15:0] b);
`ifdef DXT_DIV_SAT_EN
      logic [16:0] s;
      s = {a[15], a} - {b[15], b};
      if (s[16] != s[15]) return s[16] ? 16'h8000 : 16'h7FFF;
      return s[15:0];
`else
      return a - b;
`endif
   endfunction

   // Left neighbour of lane l is lane l-1; lane 0 takes the carry, zeroed at row start.
   always_comb begin
      prev_sel  = (c1_q == '0) ? 16'h0 : prev_q;
      dprev_vec = {bus.din[DW-17:0], prev_sel};
      dout_d    = '0;
      lhs       = '0;
      rhs       = '0;
      for (int l = 0; l < int'(PORT_SIZE); l++) begin
         lhs = dprev_vec[l*16 +: 16];
         rhs = bus.din[l*16 +: 16];
         if (l == int'(PORT_SIZE) - 1 && c1_q == CW_W'(COL_WIDTH - 1)) rhs = 16'h0;
         dout_d[l*16 +: 16] = sub16(lhs, rhs);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         v1_q    <= 1'b0;
         a1_q    <= '0;
         c1_q    <= '0;
         prev_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ren_q   <= 1'b0;
         raddr_q <= '0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         dout_q  <= '0;
      end else begin
         done_q <= 1'b0;
         v1_q   <= ren_q;
         a1_q   <= raddr_q;
         c1_q   <= col_q;
         wen_q  <= v1_q;
         // din is only meaningful one cycle after an issued read
         if (v1_q) begin
            dout_q  <= dout_d;
            waddr_q <= a1_q;
            prev_q  <= bus.din[DW-1 -: 16];
         end
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
                  ren_q   <= 1'b1;
                  raddr_q <= '0;
                  row_q   <= '0;
                  col_q   <= '0;
               end
            end
            S_RUN: begin
               if (row_q == RW_W'(ROW_NUM - 1) && col_q == CW_W'(COL_WIDTH - 1)) begin
                  ren_q   <= 1'b0;
                  state_q <= S_DRAIN;
               end else begin
                  raddr_q <= raddr_q + ADDR_W'(1);
                  if (col_q == CW_W'(COL_WIDTH - 1)) begin
                     col_q <= '0;
                     row_q <= row_q + RW_W'(1);
                  end else begin
                     col_q <= col_q + CW_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               // last write is on the bus this cycle once stage 2 is empty
               if (!v1_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.ren   = ren_q;
   assign bus.raddr = raddr_q;
   assign bus.wen   = wen_q;
   assign bus.waddr = waddr_q;
   assign bus.dout  = dout_q;

endmodule

// File: tb/tb_dxt_div.sv
// Directed self-checking bench for dxt_div with a registered-BRAM read model.
module tb_dxt_div;

   localparam int unsigned PS    = 32;
   localparam int unsigned CW    = 2;
   localparam int unsigned ROWS  = 48;
   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = PS * 16;
   localparam int          N     = PS * CW;
   localparam int          WORDS = ROWS * CW;

   logic clk;
   logic rst_n;

   int errors = 0;
   int checks = 0;

   logic [15:0]   pix      [ROWS][N];
   logic [DW-1:0] out_word [WORDS];

   int first_ren, last_ren, n_ren, ren_bad;
   int first_wen, n_wen, wen_bad, wen_after_rst;
   int n_done, done_cycle, busy_at_done, n_busy;
   logic [3:0]    snap_ctrl;
   logic [2*AW-1:0] snap_addr;
   logic [DW-1:0] snap_dout;

   dxt_div_if #(.PORT_SIZE(PS), .ADDR_W(AW)) bus ();

   dxt_div #(.PORT_SIZE(PS), .COL_WIDTH(CW), .ROW_NUM(ROWS), .ADDR_W(AW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] bram_word(input int addr);
      logic [DW-1:0] w;
      int r, c;
      r = addr / CW;
      c = addr % CW;
      w = '0;
      for (int l = 0; l < int'(PS); l++) w[l*16 +: 16] = pix[r][c*int'(PS) + l];
      return w;
   endfunction

   // Registered BRAM; garbage on din whenever no read was issued
   always @(posedge clk) begin
      if (bus.ren && int'(bus.raddr) < WORDS) bus.din <= bram_word(int'(bus.raddr));
      else bus.din <= {(DW/32){$urandom()}};
   end

   function automatic logic [15:0] out_pix(input int r, input int j);
      logic [DW-1:0] w;
      w = out_word[r*CW + j / int'(PS)];
      return w[(j % int'(PS))*16 +: 16];
   endfunction

   function automatic logic [15:0] exp_pix(input int r, input int j);
      logic [15:0] a, b;
      logic signed [16:0] s;
      a = (j == 0) ? 16'h0 : pix[r][j-1];
      b = (j == N-1) ? 16'h0 : pix[r][j];
      s = $signed({a[15], a}) - $signed({b[15], b});
`ifdef DXT_DIV_SAT_EN
      if (s > 17'sd32767) return 16'h7FFF;
      if (s < -17'sd32768) return 16'h8000;
`endif
      return s[15:0];
   endfunction

   function automatic int frame_mismatches();
      int bad;
      bad = 0;
      for (int r = 0; r < int'(ROWS); r++)
         for (int j = 0; j < N; j++)
            if (out_pix(r, j) !== exp_pix(r, j)) bad++;
      return bad;
   endfunction

   // Drives one pass and records what the DUT did, cycle 1 = first cycle after start
   task automatic run_pass(input int st2_at, input int rst_at, input int ncyc);
      first_ren = -1; last_ren = -1; n_ren = 0; ren_bad = 0;
      first_wen = -1; n_wen = 0; wen_bad = 0; wen_after_rst = 0;
      n_done = 0; done_cycle = -1; busy_at_done = -1; n_busy = 0;
      snap_ctrl = '1; snap_addr = '1; snap_dout = '1;
      for (int a = 0; a < WORDS; a++) out_word[a] = '1;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (bus.ren) begin
            if (first_ren < 0) first_ren = k;
            if (int'(bus.raddr) != n_ren || k != first_ren + n_ren) ren_bad++;
            n_ren++;
            last_ren = k;
         end
         if (bus.wen) begin
            if (first_wen < 0) first_wen = k;
            if (int'(bus.waddr) != n_wen || k != first_wen + n_wen) wen_bad++;
            if (int'(bus.waddr) < WORDS) out_word[bus.waddr] = bus.dout;
            n_wen++;
            if (rst_at > 0 && k > rst_at) wen_after_rst++;
         end
         if (bus.done) begin
            n_done++;
            done_cycle = k;
            busy_at_done = int'(bus.busy);
         end
         if (bus.busy) n_busy++;
         bus.start = (k == st2_at) ? 1'b1 : 1'b0;
         if (k == rst_at) rst_n = 1'b0;
         if (rst_at > 0 && k == rst_at + 1) begin
            snap_ctrl = {bus.ren, bus.wen, bus.busy, bus.done};
            snap_addr = {bus.raddr, bus.waddr};
            snap_dout = bus.dout;
            rst_n = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.ren, bus.wen, bus.busy, bus.done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 0000", {bus.ren, bus.wen, bus.busy, bus.done});
      end
      checks++;
      if (bus.raddr !== '0 || bus.waddr !== '0 || bus.dout !== '0) begin
         errors++;
         $display("FAIL reset_data: raddr=%0h waddr=%0h dout_nonzero=%0b want all 0",
                  bus.raddr, bus.waddr, |bus.dout);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero_frame();
      for (int r = 0; r < int'(ROWS); r++) for (int j = 0; j < N; j++) pix[r][j] = 16'h0;
      run_pass(-1, -1, 110);
      checks++;
      if (first_ren != 1 || last_ren != 96 || n_ren != 96 || ren_bad != 0) begin
         errors++;
         $display("FAIL zero_reads: first=%0d last=%0d n=%0d bad=%0d want 1 96 96 0",
                  first_ren, last_ren, n_ren, ren_bad);
      end
      checks++;
      if (first_wen != 3 || n_wen != 96 || wen_bad != 0) begin
         errors++;
         $display("FAIL zero_writes: first=%0d n=%0d bad=%0d want 3 96 0", first_wen, n_wen, wen_bad);
      end
      checks++;
      if (frame_mismatches() != 0) begin
         errors++;
         $display("FAIL zero_dout: %0d pixels differ want 0", frame_mismatches());
      end
      checks++;
      if (n_done != 1 || done_cycle != 99 || busy_at_done != 0) begin
         errors++;
         $display("FAIL zero_done: n=%0d cycle=%0d busy=%0d want 1 99 0", n_done, done_cycle, busy_at_done);
      end
      checks++;
      if (n_busy != 98) begin
         errors++;
         $display("FAIL zero_busy: busy cycles=%0d want 98", n_busy);
      end
   endtask

   task automatic test_const_one();
      for (int r = 0; r < int'(ROWS); r++) for (int j = 0; j < N; j++) pix[r][j] = 16'h1;
      run_pass(-1, -1, 110);
      checks++;
      if (out_pix(0, 0) !== 16'hFFFF || out_pix(47, 0) !== 16'hFFFF) begin
         errors++;
         $display("FAIL const_left: row0=%h row47=%h want ffff", out_pix(0, 0), out_pix(47, 0));
      end
      checks++;
      if (out_pix(0, 1) !== 16'h0 || out_pix(0, 32) !== 16'h0 || out_pix(5, 62) !== 16'h0) begin
         errors++;
         $display("FAIL const_mid: %h %h %h want 0", out_pix(0, 1), out_pix(0, 32), out_pix(5, 62));
      end
      checks++;
      if (out_pix(0, 63) !== 16'h1 || out_pix(47, 63) !== 16'h1) begin
         errors++;
         $display("FAIL const_right: row0=%h row47=%h want 0001", out_pix(0, 63), out_pix(47, 63));
      end
      checks++;
      if (frame_mismatches() != 0) begin
         errors++;
         $display("FAIL const_frame: %0d pixels differ want 0", frame_mismatches());
      end
   endtask

   task automatic test_ramp();
      for (int r = 0; r < int'(ROWS); r++) for (int j = 0; j < N; j++) pix[r][j] = 16'(j);
      run_pass(-1, -1, 110);
      checks++;
      if (out_pix(0, 0) !== 16'h0 || out_pix(1, 0) !== 16'h0) begin
         errors++;
         $display("FAIL ramp_left: row0=%h row1=%h want 0", out_pix(0, 0), out_pix(1, 0));
      end
      checks++;
      if (out_pix(0, 32) !== 16'hFFFF || out_pix(1, 32) !== 16'hFFFF || out_pix(0, 5) !== 16'hFFFF) begin
         errors++;
         $display("FAIL ramp_carry: %h %h %h want ffff", out_pix(0, 32), out_pix(1, 32), out_pix(0, 5));
      end
      checks++;
      if (out_pix(0, 63) !== 16'd62 || out_pix(30, 63) !== 16'd62) begin
         errors++;
         $display("FAIL ramp_right: %h %h want 003e", out_pix(0, 63), out_pix(30, 63));
      end
      checks++;
      if (frame_mismatches() != 0) begin
         errors++;
         $display("FAIL ramp_frame: %0d pixels differ want 0", frame_mismatches());
      end
   endtask

   task automatic test_overflow();
      logic [15:0] want32;
      for (int r = 0; r < int'(ROWS); r++) for (int j = 0; j < N; j++) pix[r][j] = 16'h0;
      pix[0][31] = 16'h7FFF;
      pix[0][32] = 16'h8000;
`ifdef DXT_DIV_SAT_EN
      want32 = 16'h7FFF;
`else
      want32 = 16'hFFFF;
`endif
      run_pass(-1, -1, 110);
      checks++;
      if (out_pix(0, 32) !== want32) begin
         errors++;
         $display("FAIL ovf_32: got %h want %h", out_pix(0, 32), want32);
      end
      checks++;
      if (out_pix(0, 31) !== 16'h8001 || out_pix(0, 33) !== 16'h8000) begin
         errors++;
         $display("FAIL ovf_neighbours: %h %h want 8001 8000", out_pix(0, 31), out_pix(0, 33));
      end
   endtask

   task automatic test_start_while_busy();
      for (int r = 0; r < int'(ROWS); r++) for (int j = 0; j < N; j++) pix[r][j] = 16'(r * 3 + j);
      run_pass(10, -1, 130);
      checks++;
      if (n_ren != 96 || ren_bad != 0 || n_wen != 96 || wen_bad != 0 || n_done != 1) begin
         errors++;
         $display("FAIL busy_start: ren=%0d/%0d wen=%0d/%0d done=%0d want 96/0 96/0 1",
                  n_ren, ren_bad, n_wen, wen_bad, n_done);
      end
      checks++;
      if (frame_mismatches() != 0) begin
         errors++;
         $display("FAIL busy_frame: %0d pixels differ want 0", frame_mismatches());
      end
   endtask

   task automatic test_reset_mid_pass();
      for (int r = 0; r < int'(ROWS); r++) for (int j = 0; j < N; j++) pix[r][j] = 16'(j * 7 - r);
      run_pass(-1, 39, 70);
      checks++;
      if (snap_ctrl !== 4'b0000 || snap_addr !== '0 || snap_dout !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: ctrl=%b addr=%h dout_nonzero=%0b want 0",
                  snap_ctrl, snap_addr, |snap_dout);
      end
      checks++;
      if (wen_after_rst != 0 || n_done != 0) begin
         errors++;
         $display("FAIL midrst_quiet: wen_after=%0d done=%0d want 0 0", wen_after_rst, n_done);
      end
      run_pass(-1, -1, 110);
      checks++;
      if (first_ren != 1 || n_ren != 96 || ren_bad != 0 || first_wen != 3 || n_wen != 96 ||
          wen_bad != 0 || done_cycle != 99) begin
         errors++;
         $display("FAIL midrst_rerun: ren %0d/%0d/%0d wen %0d/%0d/%0d done@%0d want 1/96/0 3/96/0 99",
                  first_ren, n_ren, ren_bad, first_wen, n_wen, wen_bad, done_cycle);
      end
      checks++;
      if (frame_mismatches() != 0) begin
         errors++;
         $display("FAIL midrst_frame: %0d pixels differ want 0", frame_mismatches());
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.din   = '0;
      test_reset();
      test_zero_frame();
      test_const_one();
      test_ramp();
      test_overflow();
      test_start_while_busy();
      test_reset_mid_pass();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
